// File: rtl/seq_mul_unit.sv
// Iterative shift-add multiplier: MUL low word, UMULL/SMULL full product.
// Retires STEP multiplier bits per cycle; the sign is applied once at the end.
module seq_mul_unit #(
  parameter int WIDTH     = 32,
  parameter int STEP      = 1,
  parameter int ZERO_SKIP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  input  logic             long_mul,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [1:0]       flags
);

  localparam int NCYC  = WIDTH / STEP;
  localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NCYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               neg, long_q;

  logic               accept, skip;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] acc_add, prod;
  logic               flag_n, flag_z;

  // Operand conditioning; |-2^(WIDTH-1)| still fits as an unsigned WIDTH value.
  always_comb begin
    abs_a  = (is_signed && a[WIDTH-1]) ? -a : a;
    abs_b  = (is_signed && b[WIDTH-1]) ? -b : b;
    accept = start && ((state == S_IDLE) || (state == S_DONE));
    skip   = (ZERO_SKIP != 0) && ((a == '0) || (b == '0));
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = skip ? S_DONE : S_RUN;
      S_RUN:   if (cnt == '0) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = skip ? S_DONE : S_RUN;
               else       state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: blocking assignments here build the partial-product sum in order.
  always_comb begin
    acc_add = acc;
    for (int i = 0; i < STEP; i++) begin
      if (mplier[i]) acc_add = acc_add + (mcand << i);
    end
    prod   = neg ? -acc : acc;
    flag_n = long_q ? prod[2*WIDTH-1] : prod[WIDTH-1];
    flag_z = long_q ? (prod == '0) : (prod[WIDTH-1:0] == '0);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      flags     <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == S_RUN) || (state_nxt == S_FIX);
      done  <= (state_nxt == S_DONE);
      if (accept) begin
        mcand  <= {{WIDTH{1'b0}}, abs_a};
        mplier <= abs_b;
        acc    <= '0;
        cnt    <= CNT_LOAD;
        neg    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        long_q <= long_mul;
        if (skip) begin
          result_lo <= '0;
          result_hi <= '0;
          flags     <= 2'b01;
        end
      end else if (state == S_RUN) begin
        acc    <= acc_add;
        mcand  <= mcand << STEP;
        mplier <= mplier >> STEP;
        if (cnt != '0) cnt <= cnt - CNT_ONE;
      end else if (state == S_FIX) begin
        result_lo <= prod[WIDTH-1:0];
        result_hi <= prod[2*WIDTH-1:WIDTH];
        flags     <= {flag_n, flag_z};
      end
    end
  end

endmodule
